gpio_pwm_capture_module: RTL
============================

// Module: gpio_pwm_capture_module
// PURPOSE
//   Receive side of the GPIO PWM path: measures an external PWM waveform on a GPIO pin
//   and reports its period and high time, both in CLOCK cycles, once per complete period.
//   Sits between the input pin and the control/display logic.
//   Reports a stuck-line timeout when no edge arrives for a programmable interval.
// PARAMETERS
//   CNT_WIDTH    32             width of the internal counter, Period_Cnt and High_Cnt
//   TIMEOUT_CNT  32'd5_000_000  cycles without a detected edge before timeout (100 ms at 50 MHz)
// PORTS
//   CLOCK       in   1          system clock, 50 MHz nominal
//   RST         in   1          asynchronous reset, active-high
//   En_Sig      in   1          capture enable; low forces IDLE
//   PWM_In      in   1          asynchronous PWM input from the pin
//   Period_Cnt  out  CNT_WIDTH  last measured period, in cycles
//   High_Cnt    out  CNT_WIDTH  last measured high time, in cycles
//   Done_Sig    out  1          1-cycle pulse: new Period_Cnt/High_Cnt are valid
//   Timeout_Sig out  1          level: no edge seen for TIMEOUT_CNT cycles
//   Stuck_Level out  1          synchronized line level when the timeout fired
// BEHAVIOUR
// - Reset: every output is 0, the FSM is IDLE, the counter is 0 and the sync flops are 0.
// - Input path: 2-FF synchronizer, then a delay flop. A rise or fall is detected 3 cycles
//   after the pin changes. Period/high values are exact cycle counts; the fixed lag cancels.
// - cnt holds the cycles elapsed since the last detected rise.
//   - It is loaded with 1 on the cycle after a detected rise, then increments by 1 each cycle.
//   - It saturates at all-ones.
// - FSM states:
//   - IDLE: cnt=0. Enter WAIT_RISE when En_Sig=1.
//   - WAIT_RISE: wait for the first rise, which only arms the measurement (no Done_Sig).
//     On a rise: cnt<=1, go to HIGH.
//   - HIGH: on a fall, High_Cnt<=cnt, go to LOW.
//   - LOW: on a rise, Period_Cnt<=cnt and cnt<=1. Done_Sig=1 on the cycle the new values
//     appear, i.e. the cycle after the detected edge. Go to HIGH.
// - Outputs are registered. Period_Cnt and High_Cnt hold their values until the next
//   Done_Sig or reset. High_Cnt changes at the fall, before Done_Sig.
// - Timeout:
//   - An idle counter runs in WAIT_RISE, HIGH and LOW and clears on any detected edge.
//   - When it reaches TIMEOUT_CNT: Timeout_Sig<=1, Stuck_Level<=synced level, go to WAIT_RISE.
//   - Period_Cnt and High_Cnt are not modified.
//   - Timeout_Sig clears on the next Done_Sig or when En_Sig is low.
// - En_Sig low in any state: return to IDLE the next cycle; no Done_Sig for a partial
//   period; measured outputs are held.
// - Edge cases:
//   - Pulse high for 1 synced cycle: High_Cnt=1.
//   - Period of 2 cycles: Period_Cnt=2.
//   - A rise in HIGH cannot occur, because fall and rise alternate after sync.
// - RST asserted mid-measurement: immediate return to the reset state; the partial
//   period is discarded.
// TESTING (TIMEOUT_CNT=1000 unless noted)
// 1. En_Sig=1, PWM period 100 cycles, high 30 -> no pulse after first rise; then Done_Sig
//    every 100 cycles with Period_Cnt=100, High_Cnt=30.
// 2. 50 MHz, 1 kHz 25% duty, default params -> Period_Cnt=50000, High_Cnt=12500.
// 3. PWM_In held high 1200 cycles after a rise -> Timeout_Sig=1 and Stuck_Level=1 at
//    cycle 1000 after the edge; prior counts kept; next full period clears Timeout_Sig.
// 4. Period 4, high 1 (glitch-width pulses) -> Period_Cnt=4, High_Cnt=1 each period.
// 5. En_Sig dropped mid-high, re-raised -> no Done_Sig for the broken period; first valid
//    Done_Sig one full period after the re-arming rise.
// 6. RST pulsed mid-LOW -> all outputs 0 at once; measurement restarts cleanly after release.

Source files
------------

// File: rtl/gpio_pwm_capture_if.sv
// Signal bundle between the PWM capture block and its controller / consumer.
// The controller (master) drives enable and the pin; the capture block (slave) drives measurements.
interface gpio_pwm_capture_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 En_Sig;
  logic                 PWM_In;
  logic [CNT_WIDTH-1:0] Period_Cnt;
  logic [CNT_WIDTH-1:0] High_Cnt;
  logic                 Done_Sig;
  logic                 Timeout_Sig;
  logic                 Stuck_Level;

  modport master (
    output En_Sig, PWM_In,
    input  Period_Cnt, High_Cnt, Done_Sig, Timeout_Sig, Stuck_Level
  );

  modport slave (
    input  En_Sig, PWM_In,
    output Period_Cnt, High_Cnt, Done_Sig, Timeout_Sig, Stuck_Level
  );
endinterface

// File: rtl/gpio_pwm_capture_module.sv
// Measures period and high time of an asynchronous PWM pin in clock cycles,
// reporting once per complete period, with a stuck-line timeout.
module gpio_pwm_capture_module #(
  parameter int          CNT_WIDTH   = 32,
  parameter logic [31:0] TIMEOUT_CNT = 32'd5_000_000
) (
  input  logic            CLOCK,
  input  logic            RST,
  gpio_pwm_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

  state_t               state, state_nxt;
  logic                 sync1, sync2, dly;
  logic                 rise, fall;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_WIDTH-1:0] period_q, period_nxt, high_q, high_nxt;
  logic [31:0]          idle_cnt, idle_nxt;
  logic                 done_q, done_nxt;
  logic                 timeout_q, timeout_nxt;
  logic                 stuck_q, stuck_nxt;

  // Two-flop synchronizer plus one delay flop; the fixed lag is common to
  // both edges, so measured intervals are exact.
  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
    end else begin
      sync1 <= bus.PWM_In;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign rise    = sync2 & ~dly;
  assign fall    = ~sync2 & dly;
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt_inc;
    idle_nxt    = (rise || fall) ? 32'd1 : idle_cnt + 32'd1;
    period_nxt  = period_q;
    high_nxt    = high_q;
    done_nxt    = 1'b0;
    timeout_nxt = timeout_q;
    stuck_nxt   = stuck_q;

    case (state)
      IDLE: begin
        cnt_nxt  = '0;
        idle_nxt = '0;
        if (bus.En_Sig) state_nxt = WAIT_RISE;
      end
      WAIT_RISE: if (rise) begin
        cnt_nxt   = CNT_WIDTH'(1);
        state_nxt = HIGH;
      end
      HIGH: if (fall) begin
        high_nxt  = cnt;
        state_nxt = LOW;
      end
      LOW: if (rise) begin
        period_nxt  = cnt;
        cnt_nxt     = CNT_WIDTH'(1);
        done_nxt    = 1'b1;
        timeout_nxt = 1'b0;
        state_nxt   = HIGH;
      end
      default: state_nxt = IDLE;
    endcase

    // Edges restart the idle count, so a timeout and an edge never coincide.
    if (state != IDLE && !rise && !fall && idle_cnt == TIMEOUT_CNT - 32'd1) begin
      timeout_nxt = 1'b1;
      stuck_nxt   = sync2;
      idle_nxt    = '0;
      state_nxt   = WAIT_RISE;
    end

    // Disable wins over everything; measured values are held.
    if (!bus.En_Sig) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      idle_nxt    = '0;
      done_nxt    = 1'b0;
      timeout_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      idle_cnt  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      idle_cnt  <= idle_nxt;
      period_q  <= period_nxt;
      high_q    <= high_nxt;
      done_q    <= done_nxt;
      timeout_q <= timeout_nxt;
      stuck_q   <= stuck_nxt;
    end
  end

  assign bus.Period_Cnt  = period_q;
  assign bus.High_Cnt    = high_q;
  assign bus.Done_Sig    = done_q;
  assign bus.Timeout_Sig = timeout_q;
  assign bus.Stuck_Level = stuck_q;

endmodule
